// File: rtl/pingpong_count_ctrl.sv
// Sequencer for an up/down counter: presets it to lo, sweeps lo->hi->lo n times.
// Latency: start accepted at edge 0, load in cycle 1, count_in==lo in cycle 2.
// Backpressure: none; start is ignored while busy, abort drops back to idle.
module pingpong_count_ctrl #(
    parameter int WIDTH = 4,
    parameter int SW_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo_bound,
    input  logic [WIDTH-1:0] hi_bound,
    input  logic [SW_W-1:0]  n_sweeps,
    input  logic [WIDTH-1:0] count_in,
    output logic             enable,
    output logic             upordown,
    output logic             load,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [SW_W-1:0]  sweep_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] lo_q, hi_q;
    logic [SW_W-1:0]  n_q;
    logic [SW_W-1:0]  sweep_d;
    logic             done_d, err_d, latch;

    logic             start_ok, out_of_range, last_sweep;
    logic [SW_W:0]    sweep_inc;

    assign start_ok     = (lo_bound < hi_bound) && (n_sweeps != '0);
    assign out_of_range = (count_in < lo_q) || (count_in > hi_q);
    // One extra bit so n = 2^SW_W-1 compares cleanly without wrapping.
    assign sweep_inc    = {1'b0, sweep_cnt} + 1'b1;
    assign last_sweep   = (sweep_inc == {1'b0, n_q});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            n_q       <= '0;
            sweep_cnt <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            sweep_cnt <= sweep_d;
            done      <= done_d;
            err       <= err_d;
            if (latch) begin
                lo_q <= lo_bound;
                hi_q <= hi_bound;
                n_q  <= n_sweeps;
            end
        end
    end

    // Counter controls are Mealy on count_in so the turn-around at hi/lo
    // happens in the same cycle the bound is observed, with no overshoot.
    always_comb begin
        state_d  = state_q;
        enable   = 1'b0;
        upordown = 1'b1;
        load     = 1'b0;
        data_in  = lo_q;
        busy     = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        sweep_d  = sweep_cnt;
        latch    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        latch   = 1'b1;
                        sweep_d = '0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                enable  = 1'b1;
                load    = 1'b1;
                state_d = S_UP;
            end
            S_UP: begin
                busy = 1'b1;
                if (out_of_range) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    enable = 1'b1;
                    if (count_in == hi_q) begin
                        upordown = 1'b0;
                        state_d  = S_DOWN;
                    end
                end
            end
            S_DOWN: begin
                busy = 1'b1;
                if (out_of_range) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (count_in != lo_q) begin
                    enable   = 1'b1;
                    upordown = 1'b0;
                end else begin
                    sweep_d = sweep_inc[SW_W-1:0];
                    if (last_sweep) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        enable  = 1'b1;
                        state_d = S_UP;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything: freeze the counter and leave silently.
        if (abort && (state_q != S_IDLE)) begin
            enable  = 1'b0;
            load    = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            sweep_d = sweep_cnt;
            state_d = S_IDLE;
        end
    end

endmodule

// File: tb/tb_pingpong_count_ctrl.sv
// Bench for pingpong_count_ctrl: a behavioural counter closes the loop and each
// run is checked against a count trace computed directly from the sweep rules.
module tb_pingpong_count_ctrl;

    localparam int W  = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  lo_bound = '0;
    logic [W-1:0]  hi_bound = '0;
    logic [SW-1:0] n_sweeps = '0;
    logic [W-1:0]  count_in;
    logic          enable, upordown, load, busy, done, err;
    logic [W-1:0]  data_in;
    logic [SW-1:0] sweep_cnt;

    logic          force_cnt = 1'b0;
    logic [W-1:0]  force_val = '0;
    logic [W-1:0]  cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pingpong_count_ctrl #(.WIDTH(W), .SW_W(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .lo_bound (lo_bound),
        .hi_bound (hi_bound),
        .n_sweeps (n_sweeps),
        .count_in (count_in),
        .enable   (enable),
        .upordown (upordown),
        .load     (load),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .sweep_cnt(sweep_cnt)
    );

    always #5 clk = ~clk;

    // Plant: 4-bit up/down counter with synchronous load; force_cnt models an
    // external load behind the sequencer's back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (force_cnt)
            cnt <= force_val;
        else if (enable)
            cnt <= load ? data_in : (upordown ? cnt + 1'b1 : cnt - 1'b1);
    end
    assign count_in = cnt;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        start    = 1'($urandom_range(0, 1));
        lo_bound = W'($urandom_range(0, 15));
        hi_bound = W'($urandom_range(0, 15));
        n_sweeps = SW'($urandom_range(0, 15));
    endtask

    task automatic run_sweep(input int lo, input int hi, input int n);
        int seq[$];
        int done_sw;
        seq.push_back(lo);
        for (int s = 0; s < n; s++) begin
            for (int v = lo + 1; v <= hi; v++) seq.push_back(v);
            for (int v = hi - 1; v >= lo; v--) seq.push_back(v);
        end
        start    = 1'b1;
        lo_bound = W'(lo);
        hi_bound = W'(hi);
        n_sweeps = SW'(n);
        tick();
        check_eq("load_pulse", int'(load), 1);
        check_eq("load_en", int'(enable), 1);
        check_eq("load_data", int'(data_in), lo);
        check_eq("load_busy", int'(busy), 1);
        check_eq("load_swcnt", int'(sweep_cnt), 0);
        scramble_inputs();
        done_sw = 0;
        for (int k = 0; k < seq.size(); k++) begin
            tick();
            check_eq("run_count", int'(count_in), seq[k]);
            check_eq("run_busy", int'(busy), 1);
            check_eq("run_done", int'(done), 0);
            check_eq("run_swcnt", int'(sweep_cnt), done_sw);
            check_eq("run_load", int'(load), 0);
            if (k == seq.size() - 1) begin
                check_eq("final_en", int'(enable), 0);
            end else begin
                check_eq("run_en", int'(enable), 1);
                check_eq("run_dir", int'(upordown), (seq[k+1] > seq[k]) ? 1 : 0);
            end
            if (k > 0 && seq[k] == lo) done_sw++;
            scramble_inputs();
        end
        tick();
        check_eq("done_pulse", int'(done), 1);
        check_eq("done_busy", int'(busy), 0);
        check_eq("done_en", int'(enable), 0);
        check_eq("done_swcnt", int'(sweep_cnt), n);
        check_eq("done_count", int'(count_in), lo);
        start = 1'b0;
        tick();
        check_eq("post_done", int'(done), 0);
        check_eq("post_busy", int'(busy), 0);
        check_eq("post_en", int'(enable), 0);
        check_eq("post_count", int'(count_in), lo);
        check_eq("post_swcnt", int'(sweep_cnt), n);
        check_eq("post_err", int'(err), 0);
    endtask

    task automatic bad_start(input int lo, input int hi, input int n);
        int prev_sw;
        prev_sw  = int'(sweep_cnt);
        start    = 1'b1;
        lo_bound = W'(lo);
        hi_bound = W'(hi);
        n_sweeps = SW'(n);
        tick();
        start = 1'b0;
        check_eq("bad_err", int'(err), 1);
        check_eq("bad_busy", int'(busy), 0);
        check_eq("bad_en", int'(enable), 0);
        check_eq("bad_load", int'(load), 0);
        tick();
        check_eq("bad_err_clr", int'(err), 0);
        check_eq("bad_busy2", int'(busy), 0);
        check_eq("bad_swcnt", int'(sweep_cnt), prev_sw);
    endtask

    task automatic kick(input int lo, input int hi, input int n);
        start    = 1'b1;
        lo_bound = W'(lo);
        hi_bound = W'(hi);
        n_sweeps = SW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_count(input string tag, input int val);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (int'(count_in) == val && upordown) seen = 1'b1;
        end
        check_eq(tag, int'(seen), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_en"}, int'(enable), 0);
        check_eq({tag, "_dir"}, int'(upordown), 1);
        check_eq({tag, "_load"}, int'(load), 0);
        check_eq({tag, "_data"}, int'(data_in), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_err"}, int'(err), 0);
        check_eq({tag, "_swcnt"}, int'(sweep_cnt), 0);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1 check_reset_values("rst");
        #10;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("idle_en", int'(enable), 0);
        end

        run_sweep(2, 5, 1);
        run_sweep(0, 1, 3);

        bad_start(7, 7, 2);
        bad_start(3, 5, 0);
        bad_start(9, 4, 1);

        // Abort while climbing through 3.
        kick(1, 6, 2);
        wait_count("abort_reach", 3);
        abort = 1'b1;
        #1;
        check_eq("abort_en", int'(enable), 0);
        check_eq("abort_load", int'(load), 0);
        tick();
        abort = 1'b0;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_done", int'(done), 0);
        check_eq("abort_err", int'(err), 0);
        check_eq("abort_hold", int'(count_in), 3);
        tick();
        check_eq("abort_done2", int'(done), 0);
        check_eq("abort_err2", int'(err), 0);
        check_eq("abort_hold2", int'(count_in), 3);

        // Counter yanked to 0 underneath a lo=4 run.
        kick(4, 9, 2);
        wait_count("wd_reach", 6);
        force_cnt = 1'b1;
        force_val = '0;
        tick();
        force_cnt = 1'b0;
        check_eq("wd_count", int'(count_in), 0);
        check_eq("wd_en", int'(enable), 0);
        check_eq("wd_err_early", int'(err), 0);
        tick();
        check_eq("wd_err", int'(err), 1);
        check_eq("wd_busy", int'(busy), 0);
        check_eq("wd_hold", int'(count_in), 0);
        tick();
        check_eq("wd_err_clr", int'(err), 0);
        run_sweep(4, 9, 1);

        run_sweep(0, 15, 1);
        run_sweep(3, 4, 15);
        for (int i = 0; i < 6; i++) begin
            int lo, hi, n;
            lo = $urandom_range(0, 14);
            hi = $urandom_range(lo + 1, 15);
            n  = $urandom_range(1, 3);
            run_sweep(lo, hi, n);
        end

        // Asynchronous reset in the middle of a run.
        kick(2, 12, 1);
        tick();
        tick();
        #2 rst = 1'b0;
        #1 check_reset_values("midrst");
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("midrst_idle_en", int'(enable), 0);
            check_eq("midrst_idle_busy", int'(busy), 0);
        end
        run_sweep(5, 8, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
